// File: rtl/pix_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pix_frame_pkg
// Description : Shared FSM encoding, reply bytes and sizing helpers for the
//               image-frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package pix_frame_pkg;

    // Receiver states, explicitly encoded
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_pix_hi = 2'd1;
    localparam state_t c_st_pix_lo = 2'd2;
    localparam state_t c_st_chk    = 2'd3;

    // Reply bytes sent back to the host
    localparam logic [7:0] c_ack = 8'h06;
    localparam logic [7:0] c_nak = 8'h15;

    // Bytes per pixel on the wire (1 or 2)
    function automatic int calc_bpp(input int pix_bits);
        return (pix_bits + 7) / 8;
    endfunction

    // Width of the slot index; a single slot still needs one bit
    function automatic int calc_sw(input int nslot);
        return (nslot > 1) ? $clog2(nslot) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pix_frame_rx_byte_timeout.sv
`default_nettype none
// ============================================================================
// Module      : byte_timeout
// Description : Inter-byte idle counter. Cleared by each received byte, runs
//               while enabled, pulses o_tc on the TIMEOUT_CYC-th idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_timeout #(
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic i_clk_sys,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int                 c_cnt_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Terminal count fires on the edge that completes TIMEOUT_CYC idle cycles
    assign o_tc = i_en && !i_clr && (r_cnt == c_last);

    // Idle-cycle counter, restarts on every byte or while disabled
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pix_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : pix_frame_rx
// Description : Image-frame receiver. Hunts a header byte, assembles pixels
//               into a back frame slot, verifies an XOR checksum, answers
//               ACK/NAK and flips the displayed slot only on a good frame.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_frame_rx
    import pix_frame_pkg::*;
#(
    parameter int         PIX_BITS    = 12,
    parameter int         W           = 200,
    parameter int         H           = 185,
    parameter int         NSLOT       = 2,
    parameter int         ADDR_W      = 17,
    parameter logic [7:0] HDR_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic                        i_clk_sys,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_done,
    output logic                        o_wr_en,
    output logic [ADDR_W-1:0]           o_wr_addr,
    output logic [PIX_BITS-1:0]         o_wr_data,
    output logic [calc_sw(NSLOT)-1:0]   o_disp_slot,
    output logic [ADDR_W-1:0]           o_disp_base,
    output logic                        o_busy,
    output logic [15:0]                 o_pix_cnt,
    output logic                        o_frame_done,
    output logic                        o_frame_err,
    output logic [7:0]                  o_ack_data,
    output logic                        o_ack_valid
);

    localparam int                c_bpp   = calc_bpp(PIX_BITS);
    localparam int                c_sw    = calc_sw(NSLOT);
    localparam logic [ADDR_W-1:0] c_frame = ADDR_W'(W * H);
    localparam logic [15:0]       c_last  = 16'(W * H - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_sw-1:0]     r_wslot;
    logic [ADDR_W-1:0]   r_wbase;
    logic [ADDR_W-1:0]   r_wptr;
    logic [7:0]          r_hi;
    logic [7:0]          r_chk;
    logic                w_hdr;
    logic                w_wr_fire;
    logic                w_good;
    logic                w_bad;
    logic                w_tc;
    logic                w_last_pix;
    logic                w_last_slot;
    logic [c_sw-1:0]     w_next_slot;
    logic [ADDR_W-1:0]   w_next_base;
    logic [PIX_BITS-1:0] w_pix;

    // Back slot follows the displayed one; its base is accumulated, not multiplied
    assign w_last_slot = (o_disp_slot == c_sw'(NSLOT - 1));
    assign w_next_slot = w_last_slot ? '0 : o_disp_slot + 1'b1;
    assign w_next_base = w_last_slot ? '0 : o_disp_base + c_frame;
    assign w_last_pix  = (o_pix_cnt == c_last);
    assign w_pix       = PIX_BITS'((c_bpp == 1) ? {8'h00, i_rx_data} : {r_hi, i_rx_data});
    assign o_busy      = (r_state != c_st_idle);

    byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_byte_timeout (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .i_clr     (i_rx_done),
        .i_en      (o_busy),
        .o_tc      (w_tc)
    );

    // Next-state and per-byte event decode; enable loss beats timeout beats data
    always_comb begin
        w_state_nxt = r_state;
        w_hdr       = 1'b0;
        w_wr_fire   = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (r_state != c_st_idle && !i_en) begin
            w_state_nxt = c_st_idle;
        end else if (w_tc) begin
            w_bad       = 1'b1;
            w_state_nxt = c_st_idle;
        end else if (i_rx_done) begin
            case (r_state)
                c_st_idle: begin
                    if (i_en && i_rx_data == HDR_BYTE) begin
                        w_hdr       = 1'b1;
                        w_state_nxt = c_st_pix_hi;
                    end
                end
                c_st_pix_hi: begin
                    if (c_bpp == 2) begin
                        w_state_nxt = c_st_pix_lo;
                    end else begin
                        w_wr_fire   = 1'b1;
                        w_state_nxt = w_last_pix ? c_st_chk : c_st_pix_hi;
                    end
                end
                c_st_pix_lo: begin
                    w_wr_fire   = 1'b1;
                    w_state_nxt = w_last_pix ? c_st_chk : c_st_pix_hi;
                end
                c_st_chk: begin
                    w_good      = (i_rx_data == r_chk);
                    w_bad       = (i_rx_data != r_chk);
                    w_state_nxt = c_st_idle;
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame datapath: checksum, pixel writes, commit/reject and reply strobes
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wslot      <= '0;
            r_wbase      <= '0;
            r_wptr       <= '0;
            r_hi         <= '0;
            r_chk        <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_disp_slot  <= '0;
            o_disp_base  <= '0;
            o_pix_cnt    <= '0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_ack_data   <= '0;
            o_ack_valid  <= 1'b0;
        end else begin
            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_ack_valid  <= 1'b0;
            if (w_hdr) begin
                r_chk     <= '0;
                o_pix_cnt <= '0;
                r_wslot   <= w_next_slot;
                r_wbase   <= w_next_base;
                r_wptr    <= w_next_base;
            end else if (i_rx_done && (r_state == c_st_pix_hi || r_state == c_st_pix_lo)) begin
                r_chk <= r_chk ^ i_rx_data;
            end
            if (i_rx_done && r_state == c_st_pix_hi) begin
                r_hi <= i_rx_data;
            end
            if (w_wr_fire) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= r_wptr;
                o_wr_data <= w_pix;
                r_wptr    <= r_wptr + 1'b1;
                o_pix_cnt <= o_pix_cnt + 16'd1;
            end
            if (w_good) begin
                o_frame_done <= 1'b1;
                o_ack_data   <= c_ack;
                o_ack_valid  <= 1'b1;
                o_disp_slot  <= r_wslot;
                o_disp_base  <= r_wbase;
            end
            if (w_bad) begin
                o_frame_err <= 1'b1;
                o_ack_data  <= c_nak;
                o_ack_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
